// File: rtl/controllo_pila.sv
// controllo_pila: LIFO stack controller driving a bank of DEPTH write-enabled
// WIDTH-bit registers. The storage bank lives in this file as an array of
// controllo_pila_reg instances. The controller owns the per-entry write
// enables (beta), the occupancy count/stack pointer, the read mux and the
// full/empty flags.
//
// Ports:
//   clock, reset_n          single rising-edge clock, async active-low reset
//   cmd_valid/cmd_ready     command handshake (accept on valid && ready)
//   cmd_op[2:0]             0 NOP 1 PUSH 2 POP 3 TOP 4 DUP 5 SWAP 6 CLEAR 7 illegal
//   cmd_data[WIDTH-1:0]     PUSH operand
//   rsp_valid               one-cycle completion pulse
//   rsp_data[WIDTH-1:0]     result word
//   rsp_err                 command rejected
//   count[CW-1:0]           occupancy 0..DEPTH
//   empty, full             registered occupancy flags

// One storage entry: loads i_d when i_beta is high, holds otherwise.
// Contents are deliberately not reset.
module controllo_pila_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             i_beta,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clock) begin
    if (i_beta) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

module controllo_pila #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_POP   = 3'd2;
  localparam logic [2:0] OP_TOP   = 3'd3;
  localparam logic [2:0] OP_DUP   = 3'd4;
  localparam logic [2:0] OP_SWAP  = 3'd5;
  localparam logic [2:0] OP_CLEAR = 3'd6;

  typedef enum logic {IDLE, SWAP2} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_count;
  logic             r_empty;
  logic             r_full;
  logic             r_rsp_valid;
  logic             r_rsp_err;
  logic [WIDTH-1:0] r_rsp_data;
  logic [WIDTH-1:0] r_tmp;

  logic                        w_acc;
  logic                        w_err;
  logic                        w_we;
  logic [CW-1:0]               w_waddr;
  logic [WIDTH-1:0]            w_wdata;
  logic [CW-1:0]               w_cnt_nxt;
  logic [WIDTH-1:0]            w_top;
  logic [WIDTH-1:0]            w_sec;
  logic [DEPTH-1:0]            w_beta;
  logic [DEPTH-1:0][WIDTH-1:0] w_q;

  // ---------------------------------------------------------------- storage
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    controllo_pila_reg #(.WIDTH(WIDTH)) u_reg (
      .clock (clock),
      .i_beta(w_beta[g]),
      .i_d   (w_wdata),
      .o_q   (w_q[g])
    );
  end

  // Read mux: top = entry[count-1], second = entry[count-2]. Comparing in int
  // keeps the match exact for any DEPTH; with too few entries both read 0.
  always_comb begin
    w_top = '0;
    w_sec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(r_count) == i + 1) w_top = w_q[i];
      if (int'(r_count) == i + 2) w_sec = w_q[i];
    end
  end

  assign w_acc = cmd_valid && (r_state == IDLE);

  // Rejection rules; evaluated only for an accepted command.
  always_comb begin
    w_err = 1'b0;
    case (cmd_op)
      OP_NOP:   w_err = 1'b0;
      OP_PUSH:  w_err = r_full;
      OP_POP:   w_err = r_empty;
      OP_TOP:   w_err = r_empty;
      OP_DUP:   w_err = r_empty || r_full;
      OP_SWAP:  w_err = (r_count < CW'(2));
      OP_CLEAR: w_err = 1'b0;
      default:  w_err = 1'b1;
    endcase
  end

  // Single shared write port: at most one entry is written per cycle.
  // SWAP2 writes back the saved top into the lower slot of the pair.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    if (r_state == SWAP2) begin
      w_we    = 1'b1;
      w_waddr = r_count - CW'(2);
      w_wdata = r_tmp;
    end else if (w_acc && !w_err) begin
      case (cmd_op)
        OP_PUSH: begin w_we = 1'b1; w_waddr = r_count;          w_wdata = cmd_data; end
        OP_DUP:  begin w_we = 1'b1; w_waddr = r_count;          w_wdata = w_top;    end
        OP_SWAP: begin w_we = 1'b1; w_waddr = r_count - CW'(1); w_wdata = w_sec;    end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      w_beta[i] = w_we && (int'(w_waddr) == i);
  end

  always_comb begin
    w_cnt_nxt = r_count;
    if (w_acc && !w_err) begin
      case (cmd_op)
        OP_PUSH, OP_DUP: w_cnt_nxt = r_count + CW'(1);
        OP_POP:          w_cnt_nxt = r_count - CW'(1);
        OP_CLEAR:        w_cnt_nxt = '0;
        default:         ;
      endcase
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
      r_tmp       <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
      r_count     <= w_cnt_nxt;
      r_empty     <= (w_cnt_nxt == '0);
      r_full      <= (w_cnt_nxt == CW'(DEPTH));
      case (r_state)
        IDLE: begin
          if (w_acc) begin
            if (w_err) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end else begin
              case (cmd_op)
                OP_PUSH: begin r_rsp_valid <= 1'b1; r_rsp_data <= cmd_data; end
                OP_POP,
                OP_TOP,
                OP_DUP:  begin r_rsp_valid <= 1'b1; r_rsp_data <= w_top; end
                // Response is deferred until the write-back edge.
                OP_SWAP: begin r_tmp <= w_top; r_state <= SWAP2; end
                default: r_rsp_valid <= 1'b1;  // NOP, CLEAR: data stays 0
              endcase
            end
          end
        end
        SWAP2: begin
          // entry[count-1] already holds the old second entry (the new top).
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= w_top;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign count     = r_count;
  assign empty     = r_empty;
  assign full      = r_full;

endmodule

// File: doc/controllo_pila.md
Name: controllo_pila

Overview:
- Stack controller that sequences a bank of DEPTH write-enabled WIDTH-bit registers as a LIFO.
- Each storage register has a per-entry write enable (beta): the register loads its input on a clock edge when beta=1 and holds otherwise.
- Accepts one command at a time over a valid/ready handshake and returns a one-cycle response pulse.
- Drives the per-entry write enables, the stack pointer, the read mux and the full/empty flags; sits between the command source and the storage bank.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 8, number of stack entries; must be >= 2.
- CW, $clog2(DEPTH+1), width of the occupancy count (derived; do not override).

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command this cycle.
- cmd_op  in  3  0 NOP, 1 PUSH, 2 POP, 3 TOP, 4 DUP, 5 SWAP, 6 CLEAR, 7 illegal.
- cmd_data  in  WIDTH  PUSH operand; ignored for other ops.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  WIDTH  result word; valid only while rsp_valid=1.
- rsp_err  out  1  command rejected; valid only while rsp_valid=1.
- count  out  CW  current occupancy, 0..DEPTH.
- empty  out  1  high when count==0.
- full  out  1  high when count==DEPTH.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, count=0, empty=1, full=0, cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_data=0.
  - All write enables low. Storage contents are not reset; the bench must never check unwritten entries.
- Handshake:
  - A command is accepted on a rising edge where cmd_valid && cmd_ready.
  - The source holds cmd_op/cmd_data stable while cmd_valid=1 and cmd_ready=0.
  - rsp has no backpressure.
- Entry indexing: entry 0 is the bottom; top = entry[count-1].
- FSM states: IDLE, SWAP2.
  - cmd_ready=1 in IDLE, 0 in SWAP2.
  - All ops except a legal SWAP complete in the accept cycle: state stays IDLE, rsp_valid=1 on the following cycle.
- Per-op effect on accept:
  - PUSH: entry[count]<=cmd_data; count+1; rsp_data=cmd_data.
  - POP: rsp_data=entry[count-1]; count-1.
  - TOP: rsp_data=entry[count-1]; no state change.
  - DUP: entry[count]<=entry[count-1]; count+1; rsp_data=copied value.
  - SWAP, two cycles:
    - Accept edge: tmp<=entry[count-1]; entry[count-1]<=entry[count-2]; go to SWAP2.
    - SWAP2 edge: entry[count-2]<=tmp; return to IDLE.
    - rsp_valid the cycle after the SWAP2 edge, with rsp_data=new top (old entry[count-2]).
    - Total: rsp 2 cycles after accept, one dead cycle on cmd_ready.
  - CLEAR: count<=0; storage untouched; rsp_data=0.
  - NOP: rsp_valid=1, rsp_err=0, rsp_data=0, no state change.
- Errors: rsp_valid=1, rsp_err=1, rsp_data=0, no write enable asserted, count unchanged. Error conditions:
  - PUSH when full.
  - POP or TOP when empty.
  - DUP when empty or full.
  - SWAP when count<2 (no SWAP2 entry, single-cycle response).
  - op=7.
- Write enables: at most one entry enable high per cycle, and only the addressed entry.
- Flags: full, empty and count are registered and update on the same edge as count.
- Reset asserted mid-SWAP: return to IDLE immediately, no pending response; a half-swapped pair is acceptable since count returns to 0.
- back-to-back: a new command may be accepted on the cycle its predecessor's rsp_valid is high.

Test Plan:
- Reset, then PUSH 0..7 (DEPTH=8) back-to-back -> 8 rsp with rsp_err=0, rsp_data=i; after the last, count=8, full=1, empty=0.
- When full, PUSH 0xDEAD -> rsp_err=1, rsp_data=0, count stays 8; then POP x8 -> rsp_data 7,6,...,0; then empty=1, and a further POP -> rsp_err=1.
- PUSH 5, PUSH 9, SWAP -> cmd_ready low exactly one cycle; rsp 2 cycles after accept with rsp_data=5; then POP ->5, POP ->9.
- PUSH 3, DUP, TOP -> DUP rsp_data=3, count=2, TOP rsp_data=3, count stays 2; SWAP with count=1 after one POP -> rsp_err=1.
- PUSH 1,2,3; CLEAR -> count=0, empty=1; then op=7 -> rsp_err=1; NOP -> rsp_err=0, rsp_data=0.
- PUSH 1,2; assert reset_n=0 on the cycle after SWAP accept -> immediately count=0, cmd_ready=1, rsp_valid=0; after release, no spurious rsp_valid.
